mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one external memory bus between the IF fetch port and the MEM-stage data port, so the pipelined RV32I core can run against a single unified memory.
- Accepts one request per side, serialises them onto the bus with one transaction outstanding, and routes each response back to its owner.
- Data requests have priority; a starvation limit guarantees fetch progress.
- A response timeout produces an error response instead of a hang.
- Sits between the CPU top level and the memory/bus fabric.

Parameters:
- MAX_D_STREAK, 4: consecutive data grants allowed while a fetch is waiting; on reaching it, fetch wins the next arbitration.
- TIMEOUT, 64: cycles in WAIT without bus_rvalid_i before an error response is returned (at least 2).

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-low
- if_req_i  in  1  fetch request; hold until if_gnt_o
- if_addr_i  in  32  fetch address; hold until if_gnt_o
- if_gnt_o  out  1  one-cycle pulse: fetch request accepted
- if_rvalid_o  out  1  one-cycle pulse: fetch response valid
- if_rdata_o  out  32  fetch data, valid with if_rvalid_o
- if_err_o  out  1  fetch timed out, valid with if_rvalid_o
- d_req_i  in  1  data request; hold until d_gnt_o
- d_addr_i  in  32  data address
- d_we_i  in  1  1 = store, 0 = load
- d_size_i  in  2  00 byte, 01 half, 10 word
- d_wdata_i  in  32  store data
- d_gnt_o  out  1  one-cycle pulse: data request accepted
- d_rvalid_o  out  1  one-cycle pulse: load data or store ack valid
- d_rdata_o  out  32  load data (0 for stores)
- d_err_o  out  1  data timed out, valid with d_rvalid_o
- bus_req_o  out  1  bus request; held until bus_gnt_i
- bus_addr_o  out  32  bus address
- bus_we_o  out  1  bus write enable
- bus_size_o  out  2  bus size; fetch always 10
- bus_wdata_o  out  32  bus write data
- bus_gnt_i  in  1  bus accepted the command
- bus_rvalid_i  in  1  bus response valid
- bus_rdata_i  in  32  bus response data

Behaviour:
- Reset:
  - Asynchronous, on rst_i low.
  - State IDLE, owner register = none, streak counter 0, timeout counter 0.
  - All outputs 0.
  - Reset in REQ or WAIT abandons the transaction; no response is issued after reset.
- States are IDLE, REQ and WAIT.
- IDLE:
  - Arbitration: if only one request is present, it wins.
  - If both are present, data wins unless streak == MAX_D_STREAK, in which case fetch wins.
  - The winner's gnt_o pulses combinationally in the same cycle.
  - The command is captured into registers: fetch forces we=0, size=10, wdata=0.
  - The owner is latched; next state is REQ.
- Streak counter:
  - Increments on each data grant while if_req_i=1, saturating at MAX_D_STREAK.
  - Clears on a fetch grant, and in any cycle with if_req_i=0.
- REQ:
  - bus_req_o=1; bus fields come from the captured registers, stable until bus_gnt_i.
  - bus_gnt_i=1 leads to WAIT with the timeout counter cleared.
  - bus_gnt_i and bus_rvalid_i in the same cycle complete directly: response issued, next state IDLE.
- WAIT:
  - bus_req_o=0; the timeout counter increments each cycle.
  - bus_rvalid_i leads to IDLE. On the next edge, the owner's rvalid_o=1, rdata_o=bus_rdata_i (0 if the owner's command was a store) and err_o=0.
  - If the counter reaches TIMEOUT-1 with no rvalid: owner's rvalid_o=1, rdata_o=0, err_o=1, next state IDLE.
  - A bus response arriving after a timeout is a bus protocol violation and is ignored in IDLE.
- Response timing:
  - Response outputs are registered, one pulse, owner only; the non-owner's outputs stay 0.
  - Minimum latency: request in IDLE at cycle 0, bus_req_o at cycle 1, with gnt and rvalid at cycle 1, rvalid_o at cycle 2.
- Back-to-back: the response cycle is also an IDLE arbitration cycle, so a new gnt may coincide with the previous rvalid_o.
- A request dropped before its gnt is withdrawn without side effects. gnt is never issued outside IDLE.

Decomposition:
- Package mem_arb_pkg holds:
  - the arb_state_t enum (IDLE, REQ, WAIT)
  - the owner_t enum (NONE, FETCH, DATA)
  - the size constants SZ_BYTE, SZ_HALF, SZ_WORD
  - the fetch NOP-free default word constant RSP_ERR_DATA = 0
- One sub-module, mem_arb_pick: combinational priority/starvation selector taking if_req, d_req and streak, returning the winner.

Test Plan:
- Fetch only, addr 0x0000_0100, bus gnt at +1 and rvalid at +3 with 0x0000_0013 -> if_gnt_o at cycle 0, bus_addr_o=0x100 and size=10; if_rdata_o=0x13 one cycle after rvalid; d_* outputs stay 0.
- Both requesting in the same cycle, store to 0x200 data 0xDEADBEEF size 10 -> data granted first, bus_we_o=1; d_rvalid_o with d_rdata_o=0; fetch granted in the response cycle.
- d_req_i and if_req_i held high continuously, MAX_D_STREAK=4 -> grant order D,D,D,D,F,D,D,D,D,F.
- bus_rvalid_i never asserted, TIMEOUT=64 -> owner rvalid_o=1 with err_o=1 and rdata 0 exactly 64 cycles after entering WAIT; state back to IDLE.
- bus_gnt_i and bus_rvalid_i in the same cycle with 0xCAFE0001 -> d_rvalid_o next cycle with that data; total latency 2 cycles.
- rst_i driven low mid-WAIT -> all outputs 0 immediately; after release no stale rvalid_o; a fresh fetch completes normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } owner_t;

  localparam logic [1:0]  SZ_BYTE = 2'b00;
  localparam logic [1:0]  SZ_HALF = 2'b01;
  localparam logic [1:0]  SZ_WORD = 2'b10;

  // Data returned with an error response; zero so a timed-out fetch is never a live opcode.
  localparam logic [31:0] RSP_ERR_DATA = 32'h0;

endpackage

// File: rtl/mem_arb_pick.sv
// Priority selector: data wins a contended cycle unless fetch has been passed
// over MAX_D_STREAK times in a row.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int MAX_D_STREAK = 4,
  parameter int SW           = 3
) (
  input  logic          if_req,
  input  logic          d_req,
  input  logic [SW-1:0] streak,
  output owner_t        winner
);

  always_comb begin
    winner = NONE;
    if (if_req && (!d_req || (streak == SW'(MAX_D_STREAK)))) begin
      winner = FETCH;
    end else if (d_req) begin
      winner = DATA;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory bus between the fetch and data ports: one transaction
// outstanding, data-first with a fetch starvation limit and a response timeout.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  output logic        if_err_o,
  input  logic        d_req_i,
  input  logic [31:0] d_addr_i,
  input  logic        d_we_i,
  input  logic [1:0]  d_size_i,
  input  logic [31:0] d_wdata_i,
  output logic        d_gnt_o,
  output logic        d_rvalid_o,
  output logic [31:0] d_rdata_o,
  output logic        d_err_o,
  output logic        bus_req_o,
  output logic [31:0] bus_addr_o,
  output logic        bus_we_o,
  output logic [1:0]  bus_size_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i,
  output arb_state_t  dbg_state
);

  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam int TW = $clog2(TIMEOUT);

  arb_state_t    state_q, state_d;
  owner_t        owner_q, winner;
  logic [SW-1:0] streak_q;
  logic [TW-1:0] tmo_q;
  logic [31:0]   addr_q, wdata_q;
  logic          we_q;
  logic [1:0]    size_q;
  logic          grant, respond, rsp_err, rsp_f, rsp_d;

  mem_arb_pick #(.MAX_D_STREAK(MAX_D_STREAK), .SW(SW)) u_pick (
    .if_req (if_req_i),
    .d_req  (d_req_i),
    .streak (streak_q),
    .winner (winner)
  );

  // Handshake: each side holds req and its command stable until its gnt, a
  // combinational one-cycle acknowledge issued only in IDLE. On the bus side
  // bus_req_o and its fields hold until bus_gnt_i, then one bus_rvalid_i is expected.
  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    respond = 1'b0;
    rsp_err = 1'b0;
    case (state_q)
      IDLE: begin
        if (rst_i && (winner != NONE)) begin
          grant   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (bus_gnt_i) begin
          if (bus_rvalid_i) begin
            respond = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (bus_rvalid_i) begin
          respond = 1'b1;
          state_d = IDLE;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          respond = 1'b1;
          rsp_err = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      owner_q <= NONE;
      tmo_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      size_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= (state_q == WAIT) ? tmo_q + TW'(1) : '0;
      if (grant) begin
        owner_q <= winner;
        if (winner == FETCH) begin
          addr_q  <= if_addr_i;
          we_q    <= 1'b0;
          size_q  <= SZ_WORD;
          wdata_q <= '0;
        end else begin
          addr_q  <= d_addr_i;
          we_q    <= d_we_i;
          size_q  <= d_size_i;
          wdata_q <= d_wdata_i;
        end
      end else if (respond) begin
        owner_q <= NONE;
      end
    end
  end

  // Streak only counts data wins that actually passed over a waiting fetch.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      streak_q <= '0;
    end else if (!if_req_i) begin
      streak_q <= '0;
    end else if (grant && (winner == FETCH)) begin
      streak_q <= '0;
    end else if (grant && (winner == DATA) && (streak_q != SW'(MAX_D_STREAK))) begin
      streak_q <= streak_q + SW'(1);
    end
  end

  assign rsp_f = respond && (owner_q == FETCH);
  assign rsp_d = respond && (owner_q == DATA);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      if_rvalid_o <= 1'b0;
      if_rdata_o  <= '0;
      if_err_o    <= 1'b0;
      d_rvalid_o  <= 1'b0;
      d_rdata_o   <= '0;
      d_err_o     <= 1'b0;
    end else begin
      if_rvalid_o <= rsp_f;
      if_err_o    <= rsp_f && rsp_err;
      if_rdata_o  <= !rsp_f ? '0 : (rsp_err ? RSP_ERR_DATA : bus_rdata_i);
      d_rvalid_o  <= rsp_d;
      d_err_o     <= rsp_d && rsp_err;
      d_rdata_o   <= !rsp_d ? '0 : ((rsp_err || we_q) ? RSP_ERR_DATA : bus_rdata_i);
    end
  end

  assign if_gnt_o    = grant && (winner == FETCH);
  assign d_gnt_o     = grant && (winner == DATA);
  assign bus_req_o   = (state_q == REQ);
  assign bus_addr_o  = addr_q;
  assign bus_we_o    = we_q;
  assign bus_size_o  = size_q;
  assign bus_wdata_o = wdata_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a randomized run against a
// transaction-level model with a bus responder driven by per-transaction delays.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int MAXS = 4;
  localparam int TMO  = 64;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        if_req_i = 1'b0;
  logic [31:0] if_addr_i = '0;
  logic        if_gnt_o, if_rvalid_o, if_err_o;
  logic [31:0] if_rdata_o;
  logic        d_req_i = 1'b0;
  logic [31:0] d_addr_i = '0;
  logic        d_we_i = 1'b0;
  logic [1:0]  d_size_i = '0;
  logic [31:0] d_wdata_i = '0;
  logic        d_gnt_o, d_rvalid_o, d_err_o;
  logic [31:0] d_rdata_o;
  logic        bus_req_o, bus_we_o;
  logic [31:0] bus_addr_o, bus_wdata_o;
  logic [1:0]  bus_size_o;
  logic        bus_gnt_i, bus_rvalid_i;
  logic [31:0] bus_rdata_i;
  arb_state_t  dbg_state;
  logic [139:0] all_outs;

  int n_tests = 0;
  int n_fail  = 0;

  int          cfg_gnt_dly = 0;
  int          cfg_rv_dly  = 1;
  logic        cfg_mute    = 1'b0;
  logic        cfg_fix     = 1'b0;
  logic [31:0] cfg_data    = '0;

  mem_port_arbiter #(.MAX_D_STREAK(MAXS), .TIMEOUT(TMO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o), .if_err_o(if_err_o),
    .d_req_i(d_req_i), .d_addr_i(d_addr_i), .d_we_i(d_we_i), .d_size_i(d_size_i),
    .d_wdata_i(d_wdata_i), .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o),
    .d_rdata_o(d_rdata_o), .d_err_o(d_err_o),
    .bus_req_o(bus_req_o), .bus_addr_o(bus_addr_o), .bus_we_o(bus_we_o),
    .bus_size_o(bus_size_o), .bus_wdata_o(bus_wdata_o),
    .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i),
    .dbg_state(dbg_state)
  );

  assign all_outs = {if_gnt_o, if_rvalid_o, if_rdata_o, if_err_o, d_gnt_o, d_rvalid_o,
                     d_rdata_o, d_err_o, bus_req_o, bus_addr_o, bus_we_o, bus_size_o,
                     bus_wdata_o, dbg_state};

  // Clock and watchdog
  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  // Bus responder: grants after cfg_gnt_dly REQ cycles, answers cfg_rv_dly cycles after the grant.
  initial begin : bus_model
    int          ph;
    int          cnt;
    logic [31:0] dat;
    ph = 0; cnt = 0; dat = '0;
    bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = '0;
    forever begin
      @(posedge clk_i); #1;
      bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = '0;
      if (!rst_i) begin
        ph = 0;
      end else if (ph == 2) begin
        if (cnt == 0) begin
          bus_rvalid_i = 1'b1; bus_rdata_i = dat; ph = 0;
        end else begin
          cnt--;
        end
      end else if (bus_req_o) begin
        if (ph != 1) begin cnt = cfg_gnt_dly; ph = 1; end
        if (cnt == 0) begin
          bus_gnt_i = 1'b1;
          dat = cfg_fix ? cfg_data : $urandom;
          if (cfg_mute) ph = 3;
          else if (cfg_rv_dly == 0) begin bus_rvalid_i = 1'b1; bus_rdata_i = dat; ph = 0; end
          else begin cnt = cfg_rv_dly - 1; ph = 2; end
        end else begin
          cnt--;
        end
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic do_reset();
    if_req_i = 1'b0; d_req_i = 1'b0; d_we_i = 1'b0;
    cfg_mute = 1'b0; cfg_fix = 1'b0; cfg_gnt_dly = 0; cfg_rv_dly = 1;
    rst_i = 1'b0;
    repeat (3) tick();
    rst_i = 1'b1;
  endtask

  task automatic test_reset();
    if_req_i = 1'b0; d_req_i = 1'b0;
    rst_i = 1'b0;
    tick(); tick();
    @(negedge clk_i);
    n_tests++;
    if (all_outs !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got %h expected 0", all_outs);
    end
    tick();
    rst_i = 1'b1;
    @(negedge clk_i);
    n_tests++;
    if (dbg_state !== IDLE || all_outs !== '0) begin
      n_fail++; $display("FAIL reset_release: state %0d outs %h expected IDLE and 0", dbg_state, all_outs);
    end
    tick();
  endtask

  task automatic test_fetch_only();
    int          breq_cyc, rv_cyc, rsp_cyc;
    logic [31:0] rsp_data;
    logic        rsp_err, bus_bad, side_bad;
    do_reset();
    cfg_gnt_dly = 1; cfg_rv_dly = 2; cfg_fix = 1'b1; cfg_data = 32'h0000_0013;
    breq_cyc = -1; rv_cyc = -1; rsp_cyc = -1; rsp_data = '0; rsp_err = 1'b0;
    bus_bad = 1'b0; side_bad = 1'b0;
    if_req_i = 1'b1; if_addr_i = 32'h0000_0100;
    @(negedge clk_i);
    n_tests++;
    if ({if_gnt_o, d_gnt_o} !== 2'b10) begin
      n_fail++; $display("FAIL fetch_gnt: got %b expected 10", {if_gnt_o, d_gnt_o});
    end
    tick();
    if_req_i = 1'b0;
    for (int c = 1; c < 20 && rsp_cyc < 0; c++) begin
      @(negedge clk_i);
      if (bus_req_o && breq_cyc < 0) breq_cyc = c;
      if (bus_req_o && {bus_addr_o, bus_we_o, bus_size_o, bus_wdata_o} !== {32'h100, 1'b0, SZ_WORD, 32'h0})
        bus_bad = 1'b1;
      if ({d_gnt_o, d_rvalid_o, d_err_o, d_rdata_o} !== '0) side_bad = 1'b1;
      if (bus_rvalid_i) rv_cyc = c;
      if (if_rvalid_o) begin rsp_cyc = c; rsp_data = if_rdata_o; rsp_err = if_err_o; end
      tick();
    end
    n_tests++;
    if (breq_cyc != 1) begin n_fail++; $display("FAIL fetch_bus_req_cycle: got %0d expected 1", breq_cyc); end
    n_tests++;
    if (bus_bad) begin n_fail++; $display("FAIL fetch_bus_fields: got bad cmd expected addr 100 we 0 size 10"); end
    n_tests++;
    if (side_bad) begin n_fail++; $display("FAIL fetch_d_quiet: got d activity expected 0"); end
    n_tests++;
    if (rv_cyc != 4 || rsp_cyc != 5) begin
      n_fail++; $display("FAIL fetch_latency: got rv %0d rsp %0d expected 4 5", rv_cyc, rsp_cyc);
    end
    n_tests++;
    if (rsp_data !== 32'h13 || rsp_err !== 1'b0) begin
      n_fail++; $display("FAIL fetch_rsp: got %h err %b expected 13 err 0", rsp_data, rsp_err);
    end
  endtask

  task automatic test_both_store();
    int          d_rsp_cyc, f_gnt_cyc, f_rsp_cyc;
    logic [66:0] d_cmd, f_cmd;
    logic [32:0] d_rsp;
    logic [31:0] f_data, f_rdata;
    logic        fgnt_at_rsp;
    do_reset();
    cfg_gnt_dly = 0; cfg_rv_dly = 1;
    d_rsp_cyc = -1; f_gnt_cyc = -1; f_rsp_cyc = -1;
    d_cmd = '0; f_cmd = '0; d_rsp = '1; f_data = '0; f_rdata = '1; fgnt_at_rsp = 1'b0;
    if_req_i = 1'b1; if_addr_i = 32'h0000_0300;
    d_req_i = 1'b1; d_addr_i = 32'h0000_0200; d_we_i = 1'b1; d_size_i = SZ_WORD; d_wdata_i = 32'hDEAD_BEEF;
    @(negedge clk_i);
    n_tests++;
    if ({if_gnt_o, d_gnt_o} !== 2'b01) begin
      n_fail++; $display("FAIL both_first_gnt: got %b expected 01", {if_gnt_o, d_gnt_o});
    end
    tick();
    d_req_i = 1'b0;
    for (int c = 1; c < 30 && f_rsp_cyc < 0; c++) begin
      @(negedge clk_i);
      if (bus_req_o && d_rsp_cyc < 0) d_cmd = {bus_addr_o, bus_we_o, bus_size_o, bus_wdata_o};
      if (bus_req_o && d_rsp_cyc >= 0) f_cmd = {bus_addr_o, bus_we_o, bus_size_o, bus_wdata_o};
      if (d_rvalid_o) begin d_rsp_cyc = c; d_rsp = {d_err_o, d_rdata_o}; fgnt_at_rsp = if_gnt_o; end
      if (if_gnt_o && f_gnt_cyc < 0) f_gnt_cyc = c;
      if (bus_rvalid_i && d_rsp_cyc >= 0) f_data = bus_rdata_i;
      if (if_rvalid_o) begin f_rsp_cyc = c; f_rdata = if_rdata_o; end
      tick();
      if (f_gnt_cyc >= 0) if_req_i = 1'b0;
    end
    n_tests++;
    if (d_cmd !== {32'h200, 1'b1, SZ_WORD, 32'hDEAD_BEEF}) begin
      n_fail++; $display("FAIL store_bus_cmd: got %h expected %h", d_cmd, {32'h200, 1'b1, SZ_WORD, 32'hDEAD_BEEF});
    end
    n_tests++;
    if (d_rsp_cyc != 3 || d_rsp !== 33'h0) begin
      n_fail++; $display("FAIL store_ack: got cyc %0d rsp %h expected 3 0", d_rsp_cyc, d_rsp);
    end
    n_tests++;
    if (!fgnt_at_rsp || f_gnt_cyc != 3) begin
      n_fail++; $display("FAIL fetch_gnt_in_rsp_cycle: got %0d expected 3", f_gnt_cyc);
    end
    n_tests++;
    if (f_cmd !== {32'h300, 1'b0, SZ_WORD, 32'h0} || f_rsp_cyc != 6 || f_rdata !== f_data) begin
      n_fail++; $display("FAIL fetch_after_store: got cmd %h cyc %0d data %h expected data %h cyc 6", f_cmd, f_rsp_cyc, f_rdata, f_data);
    end
  endtask

  task automatic test_streak();
    logic [9:0] got;
    int         n;
    logic       both;
    do_reset();
    cfg_gnt_dly = 0; cfg_rv_dly = 0;
    got = '0; n = 0; both = 1'b0;
    if_req_i = 1'b1; if_addr_i = 32'h400;
    d_req_i = 1'b1; d_addr_i = 32'h500; d_we_i = 1'b0; d_size_i = SZ_WORD;
    for (int c = 0; c < 200 && n < 10; c++) begin
      @(negedge clk_i);
      if (if_gnt_o && d_gnt_o) both = 1'b1;
      else if (if_gnt_o) begin got[n] = 1'b1; n++; end
      else if (d_gnt_o) begin got[n] = 1'b0; n++; end
      tick();
    end
    if_req_i = 1'b0; d_req_i = 1'b0;
    n_tests++;
    if (n != 10 || both) begin n_fail++; $display("FAIL streak_count: got %0d grants dual %b expected 10", n, both); end
    n_tests++;
    if (got !== 10'b10000_10000) begin
      n_fail++; $display("FAIL streak_order: got %b expected 1000010000 (bit i = grant i, 1 = fetch)", got);
    end
  endtask

  task automatic test_timeout();
    int         g, rsp_cyc;
    logic [34:0] rsp;
    arb_state_t st;
    do_reset();
    cfg_mute = 1'b1; cfg_gnt_dly = 0;
    g = -1; rsp_cyc = -1; rsp = '1; st = REQ;
    d_req_i = 1'b1; d_addr_i = 32'h600; d_we_i = 1'b0; d_size_i = SZ_HALF;
    tick();
    d_req_i = 1'b0;
    for (int c = 1; c < 200 && rsp_cyc < 0; c++) begin
      @(negedge clk_i);
      if (bus_gnt_i && bus_req_o) g = c;
      if (d_rvalid_o || if_rvalid_o) begin
        rsp_cyc = c; rsp = {if_rvalid_o, d_rvalid_o, d_err_o, d_rdata_o}; st = dbg_state;
      end
      tick();
    end
    n_tests++;
    if (g != 1 || rsp_cyc != g + 1 + TMO) begin
      n_fail++; $display("FAIL timeout_latency: got gnt %0d rsp %0d expected 1 %0d", g, rsp_cyc, 2 + TMO);
    end
    n_tests++;
    if (rsp !== {1'b0, 1'b1, 1'b1, 32'h0} || st !== IDLE) begin
      n_fail++; $display("FAIL timeout_rsp: got %h state %0d expected 300000000 IDLE", rsp, st);
    end
    cfg_mute = 1'b0;
  endtask

  task automatic test_same_cycle();
    int          rsp_cyc;
    logic [32:0] rsp;
    logic        f_seen;
    do_reset();
    cfg_gnt_dly = 0; cfg_rv_dly = 0; cfg_fix = 1'b1; cfg_data = 32'hCAFE_0001;
    rsp_cyc = -1; rsp = '1; f_seen = 1'b0;
    d_req_i = 1'b1; d_addr_i = 32'h700; d_we_i = 1'b0; d_size_i = SZ_WORD;
    tick();
    d_req_i = 1'b0;
    for (int c = 1; c < 20 && rsp_cyc < 0; c++) begin
      @(negedge clk_i);
      if (if_rvalid_o) f_seen = 1'b1;
      if (d_rvalid_o) begin rsp_cyc = c; rsp = {d_err_o, d_rdata_o}; end
      tick();
    end
    n_tests++;
    if (rsp_cyc != 2 || rsp !== {1'b0, 32'hCAFE_0001} || f_seen) begin
      n_fail++; $display("FAIL same_cycle_rsp: got cyc %0d rsp %h expected 2 0cafe0001", rsp_cyc, rsp);
    end
  endtask

  task automatic test_reset_mid_wait();
    logic        stale, gnt_seen;
    int          rsp_cyc;
    logic [32:0] rsp;
    do_reset();
    cfg_mute = 1'b1;
    if_req_i = 1'b1; if_addr_i = 32'h800;
    tick();
    if_req_i = 1'b0;
    tick(); tick(); tick();
    rst_i = 1'b0;
    #1;
    n_tests++;
    if (all_outs !== '0) begin n_fail++; $display("FAIL reset_mid_wait_outs: got %h expected 0", all_outs); end
    repeat (3) tick();
    cfg_mute = 1'b0; cfg_fix = 1'b1; cfg_data = 32'h1234_5678;
    rst_i = 1'b1;
    stale = 1'b0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk_i);
      if (if_rvalid_o || d_rvalid_o || bus_req_o) stale = 1'b1;
      tick();
    end
    n_tests++;
    if (stale) begin n_fail++; $display("FAIL reset_stale_rsp: got activity after reset expected none"); end
    gnt_seen = 1'b0; rsp_cyc = -1; rsp = '1;
    if_req_i = 1'b1; if_addr_i = 32'h900;
    @(negedge clk_i);
    gnt_seen = if_gnt_o;
    tick();
    if_req_i = 1'b0;
    for (int c = 1; c < 20 && rsp_cyc < 0; c++) begin
      @(negedge clk_i);
      if (if_rvalid_o) begin rsp_cyc = c; rsp = {if_err_o, if_rdata_o}; end
      tick();
    end
    n_tests++;
    if (!gnt_seen || rsp_cyc < 0 || rsp !== {1'b0, 32'h1234_5678}) begin
      n_fail++; $display("FAIL reset_fresh_fetch: got gnt %b cyc %0d rsp %h expected 1 012345678", gnt_seen, rsp_cyc, rsp);
    end
  endtask

  task automatic test_random();
    logic [32:0] exp_q[$];
    logic [32:0] e;
    logic [66:0] cmd_exp;
    logic        busy, breq_exp, own_d, ig, dg, ef, ed;
    int          s;
    do_reset();
    busy = 1'b0; breq_exp = 1'b0; own_d = 1'b0; ig = 1'b0; dg = 1'b0; s = 0; cmd_exp = '0;
    for (int c = 0; c < 600; c++) begin
      cfg_gnt_dly = $urandom_range(0, 2);
      cfg_rv_dly  = $urandom_range(0, 3);
      if (ig || (if_req_i && $urandom_range(0, 15) == 0)) if_req_i = 1'b0;
      if (!if_req_i && $urandom_range(0, 2) == 0) begin
        if_req_i = 1'b1; if_addr_i = $urandom & 32'hFFFF_FFFC;
      end
      if (dg || (d_req_i && $urandom_range(0, 15) == 0)) d_req_i = 1'b0;
      if (!d_req_i && $urandom_range(0, 2) == 0) begin
        d_req_i = 1'b1; d_addr_i = $urandom; d_we_i = 1'($urandom_range(0, 1));
        d_size_i = 2'($urandom_range(0, 2)); d_wdata_i = $urandom;
      end
      @(negedge clk_i);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        busy = 1'b0;
        n_tests++;
        if ({if_rvalid_o, if_err_o, if_rdata_o, d_rvalid_o, d_err_o, d_rdata_o} !==
            (e[32] ? {2'b00, 32'h0, 2'b10, e[31:0]} : {2'b10, e[31:0], 2'b00, 32'h0})) begin
          n_fail++; $display("FAIL rand_rsp c%0d: got if %b/%h d %b/%h expected owner_d %b data %h",
                             c, if_rvalid_o, if_rdata_o, d_rvalid_o, d_rdata_o, e[32], e[31:0]);
        end
      end else begin
        n_tests++;
        if ({if_rvalid_o, d_rvalid_o} !== 2'b00) begin
          n_fail++; $display("FAIL rand_no_rsp c%0d: got %b expected 00", c, {if_rvalid_o, d_rvalid_o});
        end
      end
      n_tests++;
      if (bus_req_o !== breq_exp) begin
        n_fail++; $display("FAIL rand_bus_req c%0d: got %b expected %b", c, bus_req_o, breq_exp);
      end
      if (breq_exp) begin
        n_tests++;
        if ({bus_addr_o, bus_we_o, bus_size_o, bus_wdata_o} !== cmd_exp) begin
          n_fail++; $display("FAIL rand_bus_cmd c%0d: got %h expected %h", c,
                             {bus_addr_o, bus_we_o, bus_size_o, bus_wdata_o}, cmd_exp);
        end
        if (bus_gnt_i) breq_exp = 1'b0;
      end
      if (bus_rvalid_i && busy) exp_q.push_back({own_d, (own_d && cmd_exp[34]) ? 32'h0 : bus_rdata_i});
      ef = !busy && if_req_i && (!d_req_i || s == MAXS);
      ed = !busy && d_req_i && !ef;
      n_tests++;
      if ({if_gnt_o, d_gnt_o} !== {ef, ed}) begin
        n_fail++; $display("FAIL rand_gnt c%0d: got %b expected %b", c, {if_gnt_o, d_gnt_o}, {ef, ed});
      end
      if (!if_req_i) s = 0;
      else if (ef) s = 0;
      else if (ed && s < MAXS) s++;
      if (ef || ed) begin
        busy = 1'b1; breq_exp = 1'b1; own_d = ed;
        cmd_exp = ef ? {if_addr_i, 1'b0, SZ_WORD, 32'h0} : {d_addr_i, d_we_i, d_size_i, d_wdata_i};
      end
      ig = if_gnt_o; dg = d_gnt_o;
      tick();
    end
    if_req_i = 1'b0; d_req_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fetch_only();
    test_both_store();
    test_streak();
    test_timeout();
    test_same_cycle();
    test_reset_mid_wait();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
